mc_regbank_arbiter: RTL and testbench
=====================================

# mc_regbank_arbiter

Shared 64-entry register bank for the MCU memory-controller bus, arbitrated against two internal fabric requesters (protocol engines). The MCU bus has absolute priority; the two internal ports share leftover cycles round-robin. The block also raises a doorbell pulse on MCU writes to the top address and flags internal-port starvation. It sits between the SB_IO tristate pads in the top level and the protocol engines.

## Interface

Parameters:
- DATA_WIDTH, 16, register/data width
- ADD_WIDTH, 6, address width; bank depth = 2**ADD_WIDTH
- STARVE_LIMIT, 64, wait cycles (1..255) before a pending internal request sets the starve flag

Ports:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- mc_ce  in  1  MCU chip enable, active low
- mc_oe  in  1  MCU output enable, active low
- mc_we  in  1  MCU write enable, active low
- mc_add  in  ADD_WIDTH  MCU address
- mc_din  in  DATA_WIDTH  MCU write data (from pad D_IN)
- mc_dout  out  DATA_WIDTH  MCU read data (to pad D_OUT)
- mc_data_oe  out  1  pad output enable
- rq_req  in  2  request per internal port, held until granted
- rq_we  in  2  per port: 1 = write, 0 = read
- rq_add  in  2*ADD_WIDTH  per-port address, port 0 in low bits
- rq_wdata  in  2*DATA_WIDTH  per-port write data, port 0 in low bits
- rq_gnt  out  2  one-cycle grant per port
- rq_rvalid  out  2  one-cycle read-data-valid per port
- rq_rdata  out  DATA_WIDTH  read data, shared; qualified by rq_rvalid
- doorbell  out  1  one-cycle pulse on MCU write to address 2**ADD_WIDTH-1
- starve  out  2  sticky per-port starvation flag

## Operation

- MCU strobes are sampled directly each clock; they are synchronous to clock by construction of the board.
- MCU cycle decode: mcu_wr = !mc_ce & !mc_we & mc_oe; mcu_rd = !mc_ce & mc_we & !mc_oe; mcu_act = mcu_wr | mcu_rd. Any other combination is idle.
- Single-port bank, one access per cycle. Priority: MCU, then internal ports.
- Arbiter FSM:
  - S_IDLE: no access.
  - S_MCU: mcu_act is high; the MCU owns the bank.
  - S_INT: an internal access is being performed.
  - Next state is evaluated each cycle: mcu_act -> S_MCU; else any rq_req -> S_INT; else S_IDLE.
- Round-robin pointer rr (reset 0) selects a port when both request. After a grant to port k, rr = ~k. A lone requester is granted regardless of rr.
- MCU write writes mc_din to bank[mc_add] every cycle the write is active. Repeated writes are idempotent.
- MCU read: mc_dout <= bank[mc_add] and mc_data_oe <= 1. mc_data_oe <= 0 in every cycle without mcu_rd.
- doorbell pulses only on the first cycle of an MCU write run to the top address, using rising-edge detect of (mcu_wr & mc_add == all-ones). Internal writes to the top address do not ring the doorbell.
- Internal write: the bank is written in the grant cycle. Internal read: rq_rdata and rq_rvalid[k] follow on the next cycle.
- Starve: a per-port 8-bit wait counter increments while rq_req[k] & !rq_gnt[k]. It clears on grant or when the request drops. When it reaches STARVE_LIMIT, starve[k] is set and stays set until reset. The counter saturates.
- A requester may drop rq_req before grant; the request is withdrawn and no access occurs.
- Bank contents are not reset.

## Timing

- Reset values: mc_dout 0, mc_data_oe 0, rq_gnt 0, rq_rvalid 0, rq_rdata 0, doorbell 0, starve 0, rr 0, counters 0, FSM S_IDLE.
- MCU read latency: 1 clock from the sampled strobe to mc_dout/mc_data_oe valid. mc_data_oe drops 1 clock after the strobe ends.
- Internal grant: rq_gnt[k] is registered and asserted in the cycle after the arbitration decision. The access occurs in that same gnt cycle. Requester sees gnt and may change req/add on the following edge.
- Internal read latency: rq_rvalid 1 cycle after rq_gnt. Back-to-back grants are allowed, giving one access per cycle.
- MCU preemption: if mcu_act rises in the cycle an internal decision would be made, no gnt is issued. The requester waits.
- Read-after-write ordering is strict cycle order. An internal read granted the cycle after an MCU write to the same address returns the new data.
- Reset asserted mid-operation: pending gnt/rvalid are suppressed at the next edge. Requesters must re-present. Starve counters clear.

## Test plan

- MCU write 0x5A5A to address 3, then read address 3 -> mc_dout = 0x5A5A with mc_data_oe=1 one clock after the read strobe, and mc_data_oe=0 one clock after ce rises.
- rq_req=2'b11 held continuously, both ports reading, no MCU activity -> grants alternate 01,10,01,...; each rq_rvalid arrives 1 cycle after its gnt with the correct bank data.
- MCU read held for 100 cycles while port 0 requests with STARVE_LIMIT=64 -> no rq_gnt[0] during the MCU run, starve[0]=1 after 64 waiting cycles; the grant follows within 2 cycles of ce rising, and starve stays 1.
- MCU write to address 63 held 5 cycles, followed by a port-1 write to 63 -> exactly one doorbell pulse, on the second cycle of the MCU write; no pulse from the port-1 write.
- Port 0 write 0x1234 to address 7, with an MCU read of address 7 starting the cycle after gnt -> mc_dout = 0x1234.
- Reset pulsed low one cycle after rq_gnt[1] for a read -> rq_rvalid[1] never asserts; all outputs at reset values; after release the still-held request is granted again.

Source files
------------

// File: rtl/mc_regbank_arbiter.sv
// Shared 64-entry register bank: MCU bus has absolute priority, two internal
// ports share leftover cycles round-robin; doorbell on MCU top-address write.
module mc_regbank_arbiter #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADD_WIDTH    = 6,
    parameter int STARVE_LIMIT = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mc_ce,
    input  logic                      mc_oe,
    input  logic                      mc_we,
    input  logic [ADD_WIDTH-1:0]      mc_add,
    input  logic [DATA_WIDTH-1:0]     mc_din,
    output logic [DATA_WIDTH-1:0]     mc_dout,
    output logic                      mc_data_oe,
    input  logic [1:0]                rq_req,
    input  logic [1:0]                rq_we,
    input  logic [2*ADD_WIDTH-1:0]    rq_add,
    input  logic [2*DATA_WIDTH-1:0]   rq_wdata,
    output logic [1:0]                rq_gnt,
    output logic [1:0]                rq_rvalid,
    output logic [DATA_WIDTH-1:0]     rq_rdata,
    output logic                      doorbell,
    output logic [1:0]                starve
);

    // state  | meaning
    // S_IDLE | no bank access this cycle
    // S_MCU  | MCU strobes active, MCU owns the bank
    // S_INT  | internal grant cycle; access for port sel_q happens now
    typedef enum logic [1:0] {S_IDLE, S_MCU, S_INT} state_t;

    localparam int                   DEPTH      = 2**ADD_WIDTH;
    localparam logic [7:0]           STARVE_LIM = 8'(STARVE_LIMIT);
    localparam logic [ADD_WIDTH-1:0] TOP_ADD    = '1;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   rr_q, rr_d;

    logic mcu_wr, mcu_rd, mcu_act;
    logic [1:0] gnt;
    logic [1:0] eligible;

    logic                  int_go;
    logic                  int_we;
    logic [ADD_WIDTH-1:0]  int_add;
    logic [DATA_WIDTH-1:0] int_wdata;

    logic db_hit, db_hit_q;

    logic [1:0][7:0] cnt_q, cnt_d;
    logic [1:0]      starve_hit;

    logic [DATA_WIDTH-1:0] bank [DEPTH];

    assign mcu_wr  = !mc_ce && !mc_we &&  mc_oe;
    assign mcu_rd  = !mc_ce &&  mc_we && !mc_oe;
    assign mcu_act = mcu_wr || mcu_rd;

    // A port already holding a grant this cycle is not re-eligible, so a
    // request still held during its grant cycle is not serviced twice.
    assign gnt      = (state_q == S_INT) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign rq_gnt   = gnt;
    assign eligible = rq_req & ~gnt;

    assign int_go    = (state_q == S_INT);
    assign int_we    = rq_we[sel_q];
    assign int_add   = sel_q ? rq_add[2*ADD_WIDTH-1 -: ADD_WIDTH]
                             : rq_add[ADD_WIDTH-1:0];
    assign int_wdata = sel_q ? rq_wdata[2*DATA_WIDTH-1 -: DATA_WIDTH]
                             : rq_wdata[DATA_WIDTH-1:0];

    assign db_hit = mcu_wr && (mc_add == TOP_ADD);

    always_comb begin
        state_d = S_IDLE;
        sel_d   = sel_q;
        rr_d    = rr_q;
        if (mcu_act) begin
            state_d = S_MCU;
        end else if (|eligible) begin
            state_d = S_INT;
            case (eligible)
                2'b01:   sel_d = 1'b0;
                2'b10:   sel_d = 1'b1;
                default: sel_d = rr_q;
            endcase
            rr_d = ~sel_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rr_q    <= rr_d;
        end
    end

    // MCU write is issued last so it wins a same-address collision with an
    // internal write whose grant was committed the cycle before.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (int_go && int_we) bank[int_add] <= int_wdata;
            if (mcu_wr)           bank[mc_add]  <= mc_din;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mc_dout    <= '0;
            mc_data_oe <= 1'b0;
            rq_rvalid  <= 2'b00;
            rq_rdata   <= '0;
            db_hit_q   <= 1'b0;
            doorbell   <= 1'b0;
        end else begin
            mc_data_oe <= mcu_rd;
            if (mcu_rd) mc_dout <= bank[mc_add];
            rq_rvalid <= (int_go && !int_we) ? gnt : 2'b00;
            if (int_go && !int_we) rq_rdata <= bank[int_add];
            db_hit_q <= db_hit;
            doorbell <= db_hit && !db_hit_q;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        starve_hit = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (!rq_req[k] || gnt[k]) begin
                cnt_d[k] = 8'd0;
            end else if (cnt_q[k] != 8'hFF) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
            starve_hit[k] = (cnt_d[k] >= STARVE_LIM);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q  <= '0;
            starve <= 2'b00;
        end else begin
            cnt_q  <= cnt_d;
            starve <= starve | starve_hit;
        end
    end

endmodule

// File: tb/tb_mc_regbank_arbiter.sv
// Directed bench for mc_regbank_arbiter: MCU access, round-robin, starvation,
// doorbell, read-after-write and mid-operation reset.
module tb_mc_regbank_arbiter;

    logic        clock;
    logic        reset;
    logic        mc_ce, mc_oe, mc_we;
    logic [5:0]  mc_add;
    logic [15:0] mc_din;
    logic [15:0] mc_dout;
    logic        mc_data_oe;
    logic [1:0]  rq_req, rq_we;
    logic [11:0] rq_add;
    logic [31:0] rq_wdata;
    logic [1:0]  rq_gnt, rq_rvalid;
    logic [15:0] rq_rdata;
    logic        doorbell;
    logic [1:0]  starve;

    int n_tests = 0;
    int n_fail  = 0;
    int db_cnt  = 0;

    mc_regbank_arbiter #(.DATA_WIDTH(16), .ADD_WIDTH(6), .STARVE_LIMIT(64)) dut (
        .clock(clock), .reset(reset),
        .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we),
        .mc_add(mc_add), .mc_din(mc_din),
        .mc_dout(mc_dout), .mc_data_oe(mc_data_oe),
        .rq_req(rq_req), .rq_we(rq_we), .rq_add(rq_add), .rq_wdata(rq_wdata),
        .rq_gnt(rq_gnt), .rq_rvalid(rq_rvalid), .rq_rdata(rq_rdata),
        .doorbell(doorbell), .starve(starve)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mcu_idle();
        mc_ce = 1'b1; mc_oe = 1'b1; mc_we = 1'b1;
    endtask

    task automatic mcu_write(input logic [5:0] a, input logic [15:0] d);
        mc_ce = 1'b0; mc_oe = 1'b1; mc_we = 1'b0; mc_add = a; mc_din = d;
    endtask

    task automatic mcu_read(input logic [5:0] a);
        mc_ce = 1'b0; mc_oe = 1'b0; mc_we = 1'b1; mc_add = a;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        mcu_idle();
        mc_add = '0; mc_din = '0;
        rq_req = 2'b00; rq_we = 2'b00; rq_add = '0; rq_wdata = '0;
        tick(); tick();
        chk("rst_dout",   32'(mc_dout),    32'h0);
        chk("rst_doe",    32'(mc_data_oe), 32'h0);
        chk("rst_gnt",    32'(rq_gnt),     32'h0);
        chk("rst_rvalid", 32'(rq_rvalid),  32'h0);
        chk("rst_rdata",  32'(rq_rdata),   32'h0);
        chk("rst_db",     32'(doorbell),   32'h0);
        chk("rst_starve", 32'(starve),     32'h0);
        reset = 1'b1;
        tick();

        // MCU write then read
        mcu_write(6'd3, 16'h5A5A); tick();
        mcu_read(6'd3); tick();
        chk("mcu_rd_data", 32'(mc_dout),    32'h5A5A);
        chk("mcu_rd_oe",   32'(mc_data_oe), 32'h1);
        mcu_idle(); tick();
        chk("mcu_oe_drop", 32'(mc_data_oe), 32'h0);

        mcu_write(6'd10, 16'h1111); tick();
        mcu_write(6'd20, 16'h2222); tick();
        mcu_idle(); tick();

        // Round-robin with both ports reading
        rq_add = {6'd20, 6'd10}; rq_we = 2'b00; rq_req = 2'b11;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("rr_gnt", 32'(rq_gnt), (k % 2 == 1) ? 32'h1 : 32'h2);
            if (k >= 2) begin
                chk("rr_rvalid", 32'(rq_rvalid), (k % 2 == 0) ? 32'h1 : 32'h2);
                chk("rr_rdata",  32'(rq_rdata),  (k % 2 == 0) ? 32'h1111 : 32'h2222);
            end
        end
        rq_req = 2'b00;
        tick();
        chk("rr_last_rvalid", 32'(rq_rvalid), 32'h2);
        chk("rr_last_rdata",  32'(rq_rdata),  32'h2222);
        chk("rr_idle_gnt",    32'(rq_gnt),    32'h0);
        tick();

        // MCU preempts and starves port 0
        mcu_read(6'd3);
        rq_add = {6'd20, 6'd3}; rq_req = 2'b01;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("starve_nogrant", 32'(rq_gnt), 32'h0);
            if (i == 63) chk("starve_before", 32'(starve), 32'h0);
            if (i == 64) chk("starve_set",    32'(starve), 32'h1);
        end
        chk("starve_mcu_dout", 32'(mc_dout), 32'h5A5A);
        mcu_idle(); tick();
        chk("starve_gnt_after", 32'(rq_gnt), 32'h1);
        chk("starve_sticky",    32'(starve), 32'h1);
        rq_req = 2'b00; tick();
        chk("starve_rvalid", 32'(rq_rvalid), 32'h1);
        chk("starve_rdata",  32'(rq_rdata),  32'h5A5A);
        tick();

        // Doorbell on MCU top-address write, not on internal write
        db_cnt = 0;
        mcu_write(6'd63, 16'hBEEF);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (doorbell) db_cnt++;
            if (i == 1) chk("db_second_cycle", 32'(doorbell), 32'h1);
        end
        mcu_idle();
        rq_req = 2'b10; rq_we = 2'b10; rq_add = {6'd63, 6'd3}; rq_wdata = {16'hCAFE, 16'h0000};
        tick();
        chk("db_int_gnt", 32'(rq_gnt), 32'h2);
        if (doorbell) db_cnt++;
        rq_req = 2'b00;
        tick();
        if (doorbell) db_cnt++;
        rq_we = 2'b00;
        tick();
        if (doorbell) db_cnt++;
        chk("db_count", 32'(db_cnt), 32'h1);
        mcu_read(6'd63); tick();
        chk("db_int_wr_data", 32'(mc_dout), 32'hCAFE);
        mcu_idle(); tick();

        // Internal write followed by MCU read of the same address
        rq_req = 2'b01; rq_we = 2'b01; rq_add = {6'd20, 6'd7}; rq_wdata = {16'h0000, 16'h1234};
        tick();
        chk("raw_gnt", 32'(rq_gnt), 32'h1);
        rq_req = 2'b00;
        tick();
        rq_we = 2'b00;
        mcu_read(6'd7); tick();
        chk("raw_mcu_dout", 32'(mc_dout), 32'h1234);
        mcu_idle(); tick();
        chk("starve_still", 32'(starve), 32'h1);

        // Reset during a port-1 read grant cycle
        rq_req = 2'b10; rq_we = 2'b00; rq_add = {6'd20, 6'd7};
        tick();
        chk("rst_mid_gnt", 32'(rq_gnt), 32'h2);
        reset = 1'b0;
        tick();
        chk("rst_mid_rvalid", 32'(rq_rvalid), 32'h0);
        chk("rst_mid_gnt0",   32'(rq_gnt),    32'h0);
        chk("rst_mid_starve", 32'(starve),    32'h0);
        chk("rst_mid_dout",   32'(mc_dout),   32'h0);
        chk("rst_mid_rdata",  32'(rq_rdata),  32'h0);
        reset = 1'b1;
        tick();
        chk("rst_regrant",        32'(rq_gnt),    32'h2);
        chk("rst_regrant_rvalid", 32'(rq_rvalid), 32'h0);
        rq_req = 2'b00;
        tick();
        chk("rst_after_rvalid", 32'(rq_rvalid), 32'h2);
        chk("rst_after_rdata",  32'(rq_rdata),  32'h2222);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
